// File: rtl/menu_controller_if.sv
// menu_controller_if: pushbutton/vsync inputs and display/playback outputs of the menu sequencer
//  master: button, song_done and vsync driver; reads screen, selection and song control
//  slave : menu_controller
interface menu_controller_if;
    logic       btn_up;
    logic       btn_down;
    logic       btn_select;
    logic       btn_back;
    logic       song_done;
    logic       vsync_in;
    logic [2:0] screen_out;
    logic [2:0] selection_out;
    logic [10:0] selector_y_out;
    logic       song_start;
    logic [2:0] song_id_out;
    modport master (
        output btn_up, btn_down, btn_select, btn_back, song_done, vsync_in,
        input  screen_out, selection_out, selector_y_out, song_start, song_id_out
    );
    modport slave (
        input  btn_up, btn_down, btn_select, btn_back, song_done, vsync_in,
        output screen_out, selection_out, selector_y_out, song_start, song_id_out
    );
endinterface

// File: rtl/menu_controller.sv
// menu_controller: button-driven menu FSM with frame-synchronous display outputs
//  clk_65mhz : pixel clock
//  reset     : asynchronous active-high reset
//  bus       : buttons, song_done, vsync_in in; screen/selection/selector_y, song_start/song_id out
module menu_controller #(
    parameter int SONG_ITEMS = 5,
    parameter int SEL_Y_BASE = 50,
    parameter int SEL_Y_STEP = 100
) (
    input logic             clk_65mhz,
    input logic             reset,
    menu_controller_if.slave bus
);
    typedef enum logic [1:0] {MAIN, SONG_MENU, KEYBOARD, PLAY} state_t;
    localparam logic [2:0] LAST = 3'(SONG_ITEMS - 1);
    state_t     state, state_n;
    logic [2:0] sel, sel_n, song_id, song_id_n;
    logic [2:0] screen, selection;
    logic [10:0] sel_y;
    logic       start, start_n;
    logic [3:0] btn, btn_prev, press;
    logic       vs_prev, frame_start;
    logic       up, dn, sl, bk;
    // button order {back, select, down, up}; history resets to 1 so a held button is not a press
    assign btn         = {bus.btn_back, bus.btn_select, bus.btn_down, bus.btn_up};
    assign press       = btn & ~btn_prev;
    assign up          = press[0] & ~press[1];
    assign dn          = press[1] & ~press[0];
    assign sl          = press[2];
    assign bk          = press[3];
    assign frame_start = vs_prev & ~bus.vsync_in;
    always_ff @(posedge clk_65mhz or posedge reset) begin
        if (reset) begin
            state    <= MAIN;
            sel      <= '0;
            song_id  <= '0;
            start    <= 1'b0;
            btn_prev <= '1;
            vs_prev  <= 1'b1;
        end else begin
            state    <= state_n;
            sel      <= sel_n;
            song_id  <= song_id_n;
            start    <= start_n;
            btn_prev <= btn;
            vs_prev  <= bus.vsync_in;
        end
    end
    // back outranks select, select outranks up/down; song_done only matters in PLAY
    always_comb begin
        state_n = state;
        sel_n   = sel;
        case (state)
            MAIN: begin
                if (!bk && sl) begin
                    state_n = sel[0] ? KEYBOARD : SONG_MENU;
                    sel_n   = '0;
                end else if (!bk && (up || dn)) begin
                    sel_n = {2'b00, ~sel[0]};
                end
            end
            SONG_MENU: begin
                if (bk) begin
                    state_n = MAIN;
                    sel_n   = '0;
                end else if (sl) begin
                    state_n = PLAY;
                end else if (up) begin
                    sel_n = (sel == 3'd0) ? LAST : sel - 3'd1;
                end else if (dn) begin
                    sel_n = (sel == LAST) ? 3'd0 : sel + 3'd1;
                end
            end
            KEYBOARD: begin
                if (bk) begin
                    state_n = MAIN;
                    sel_n   = '0;
                end
            end
            default: begin
                if (bk || bus.song_done) state_n = SONG_MENU;
            end
        endcase
    end
    always_comb begin
        start_n   = (state == SONG_MENU) && !bk && sl;
        song_id_n = start_n ? sel : song_id;
    end
    // display registers sample the pre-event state at frame start, so nothing changes mid-frame
    always_ff @(posedge clk_65mhz or posedge reset) begin
        if (reset) begin
            screen    <= '0;
            selection <= '0;
            sel_y     <= 11'(SEL_Y_BASE);
        end else if (frame_start) begin
            screen    <= {1'b0, state};
            selection <= sel;
            sel_y     <= 11'(SEL_Y_BASE + int'(sel) * SEL_Y_STEP);
        end
    end
    assign bus.screen_out     = screen;
    assign bus.selection_out  = selection;
    assign bus.selector_y_out = sel_y;
    assign bus.song_start     = start;
    assign bus.song_id_out    = song_id;
endmodule

// File: tb/tb_menu_controller.sv
// tb_menu_controller: directed and randomized checks of menu_controller against a behavioural model
module tb_menu_controller;
    localparam int ITEMS = 5;
    localparam int FRAME = 20;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [3:0] btns = 4'b0100;
    int checks = 0;
    int errors = 0;
    int fcnt = 0;
    menu_controller_if bus();
    menu_controller #(.SONG_ITEMS(ITEMS), .SEL_Y_BASE(50), .SEL_Y_STEP(100)) dut (
        .clk_65mhz(clk),
        .reset(reset),
        .bus(bus)
    );
    assign bus.btn_up     = btns[0];
    assign bus.btn_down   = btns[1];
    assign bus.btn_select = btns[2];
    assign bus.btn_back   = btns[3];
    always #5 clk = ~clk;
    initial begin
        bus.song_done = 1'b0;
        bus.vsync_in  = 1'b1;
    end
    task automatic chk(input string n, input int a, input int e);
        checks++;
        if (a != e) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", n, a, e);
        end
    endtask
    // model: menu 0 MAIN, 1 SONG_MENU, 2 KEYBOARD, 3 PLAY; items counted per menu
    int ms = 0, msel = 0, mid = 0, dscr = 0, dsel = 0, n;
    bit mstart = 0, pv = 1, fr;
    bit [3:0] pb = '1, b, e;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            ms = 0; msel = 0; mid = 0; dscr = 0; dsel = 0; mstart = 0; pb = '1; pv = 1;
        end else begin
            b  = btns;
            e  = b & ~pb;
            fr = pv && !bus.vsync_in;
            if (fr) begin
                dscr = ms;
                dsel = msel;
            end
            mstart = 0;
            if (ms == 3) begin
                if (e[3] || bus.song_done) ms = 1;
            end else if (e[3]) begin
                if (ms != 0) begin
                    ms = 0;
                    msel = 0;
                end
            end else if (e[2]) begin
                if (ms == 0) begin
                    ms = (msel == 0) ? 1 : 2;
                    msel = 0;
                end else if (ms == 1) begin
                    ms = 3;
                    mid = msel;
                    mstart = 1;
                end
            end else if (e[0] != e[1]) begin
                n = (ms == 0) ? 2 : (ms == 1) ? ITEMS : 0;
                if (n > 0) msel = (msel + (e[1] ? 1 : n - 1)) % n;
            end
            pb = b;
            pv = bus.vsync_in;
        end
    end
    bit prev_start = 0;
    always @(negedge clk) begin
        chk("screen", int'(bus.screen_out), dscr);
        chk("selection", int'(bus.selection_out), dsel);
        chk("selector_y", int'(bus.selector_y_out), 50 + dsel * 100);
        chk("song_start", int'(bus.song_start), int'(mstart));
        chk("song_id", int'(bus.song_id_out), mid);
        if (bus.song_start && prev_start) chk("start_twice", 1, 0);
        prev_start = bus.song_start;
    end
    task automatic tick();
        @(posedge clk);
        #3;
        fcnt++;
        bus.vsync_in = (fcnt % FRAME) >= 2;
    endtask
    task automatic wait_fall();
        do tick(); while (fcnt % FRAME != 0);
    endtask
    task automatic wait_frame();
        wait_fall();
        tick();
        tick();
    endtask
    task automatic press(input logic [3:0] m);
        btns = m;
        tick();
        btns = '0;
        tick();
    endtask
    initial begin
        repeat (3) tick();
        reset = 1'b0;
        repeat (3) tick();
        btns = '0;
        repeat (3) wait_frame();
        chk("rst_screen", int'(bus.screen_out), 0);
        chk("rst_sel", int'(bus.selection_out), 0);
        chk("rst_y", int'(bus.selector_y_out), 50);
        press(4'b0010); press(4'b0010); press(4'b0001);
        wait_frame();
        chk("main_sel", int'(bus.selection_out), 1);
        chk("main_y", int'(bus.selector_y_out), 150);
        press(4'b0100);
        wait_frame();
        chk("kbd_screen", int'(bus.screen_out), 2);
        press(4'b1000);
        press(4'b0100);
        wait_frame();
        chk("songs_screen", int'(bus.screen_out), 1);
        press(4'b0001);
        wait_frame();
        chk("songs_wrap_sel", int'(bus.selection_out), 4);
        chk("songs_wrap_y", int'(bus.selector_y_out), 450);
        btns = 4'b0100;
        tick();
        chk("start_pulse", int'(bus.song_start), 1);
        chk("start_id", int'(bus.song_id_out), 4);
        btns = '0;
        tick();
        chk("start_end", int'(bus.song_start), 0);
        wait_frame();
        chk("play_screen", int'(bus.screen_out), 3);
        bus.song_done = 1'b1;
        tick();
        bus.song_done = 1'b0;
        wait_frame();
        chk("done_screen", int'(bus.screen_out), 1);
        chk("done_sel", int'(bus.selection_out), 4);
        press(4'b1000);
        wait_frame();
        chk("back_screen", int'(bus.screen_out), 0);
        chk("back_sel", int'(bus.selection_out), 0);
        press(4'b0011);
        wait_frame();
        chk("updown_sel", int'(bus.selection_out), 0);
        press(4'b0100);
        btns = 4'b1100;
        tick();
        chk("backsel_nostart", int'(bus.song_start), 0);
        btns = '0;
        tick();
        wait_frame();
        chk("backsel_screen", int'(bus.screen_out), 0);
        wait_fall();
        btns = 4'b0010;
        tick();
        btns = '0;
        tick();
        chk("frame_edge_hold", int'(bus.selection_out), 0);
        wait_frame();
        chk("frame_edge_next", int'(bus.selection_out), 1);
        for (int i = 0; i < 4000; i++) begin
            tick();
            for (int j = 0; j < 4; j++)
                if ($urandom_range(0, 5) == 0) btns[j] = ~btns[j];
            bus.song_done = (ms == 3) && ($urandom_range(0, 15) == 0);
            reset = ($urandom_range(0, 699) == 0);
        end
        reset = 1'b0;
        repeat (3) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
